// File: rtl/cache_types_pkg.sv
// Shared MSHR types: entry lifecycle enum, per-entry record, and the
// widths the entry record is built from.
package cache_types_pkg;

    localparam int MSHR_ENTRIES     = 8;
    localparam int MSHR_BLOCK_WORDS = 4;
    localparam int MSHR_WORD_W      = 32;
    localparam int MSHR_ADDR_W      = 32;
    localparam int MSHR_UUID_W      = 8;

    localparam int MSHR_IDX_W  = $clog2(MSHR_ENTRIES);
    localparam int MSHR_SEQ_W  = MSHR_UUID_W - MSHR_IDX_W;
    localparam int MSHR_WIDX_W = $clog2(MSHR_BLOCK_WORDS);
    localparam int MSHR_OFF_W  = MSHR_WIDX_W + $clog2(MSHR_WORD_W / 8);
    localparam int MSHR_OCC_W  = $clog2(MSHR_ENTRIES + 1);

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        PEND   = 2'd1,
        ISSUED = 2'd2
    } mshr_state_t;

    typedef struct packed {
        mshr_state_t                              state;
        logic [MSHR_UUID_W-1:0]                   uuid;
        logic [MSHR_ADDR_W-1:0]                   block_addr;
        logic [MSHR_BLOCK_WORDS-1:0]              write_status;
        logic [MSHR_BLOCK_WORDS*MSHR_WORD_W-1:0]  write_block;
    } mshr_entry_t;

endpackage

// File: rtl/cache_mshr_file_if.sv
// Miss-request, memory-issue and fill-return signals of the MSHR file.
// master = bank/memory side, slave = the MSHR file.
interface cache_mshr_file_if
    import cache_types_pkg::*;
#(
    parameter int BLOCK_WORDS = MSHR_BLOCK_WORDS,
    parameter int WORD_W      = MSHR_WORD_W,
    parameter int ADDR_W      = MSHR_ADDR_W,
    parameter int UUID_W      = MSHR_UUID_W
);
    logic                          req_valid;
    logic                          req_ready;
    logic                          req_rw;
    logic [ADDR_W-1:0]             req_addr;
    logic [WORD_W-1:0]             req_data;
    logic [UUID_W-1:0]             req_uuid;
    logic                          req_merged;

    logic                          issue_valid;
    logic                          issue_ready;
    logic [UUID_W-1:0]             issue_uuid;
    logic [ADDR_W-1:0]             issue_block_addr;
    logic [BLOCK_WORDS-1:0]        issue_write_status;
    logic [BLOCK_WORDS*WORD_W-1:0] issue_write_block;

    logic                          fill_valid;
    logic [UUID_W-1:0]             fill_uuid;
    logic                          fill_err;

    modport master (
        output req_valid, req_rw, req_addr, req_data, issue_ready, fill_valid, fill_uuid,
        input  req_ready, req_uuid, req_merged, issue_valid, issue_uuid, issue_block_addr,
               issue_write_status, issue_write_block, fill_err
    );

    modport slave (
        input  req_valid, req_rw, req_addr, req_data, issue_ready, fill_valid, fill_uuid,
        output req_ready, req_uuid, req_merged, issue_valid, issue_uuid, issue_block_addr,
               issue_write_status, issue_write_block, fill_err
    );
endinterface

// File: rtl/mshr_index_fifo.sv
// In-order queue of PEND entry indices; head visible combinationally, push lands next cycle.
// No full flag: it only ever holds PEND entries, so it cannot be overfilled.
module mshr_index_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 3
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] head_dat,
    output logic         empty
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [PW:0]  wr_q;
    logic [PW:0]  rd_q;

    // Top pointer bit is the wrap phase, so a full queue never reads as empty.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (push) wr_q <= wr_q + (PW+1)'(1);
            if (pop)  rd_q <= rd_q + (PW+1)'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (push) mem[wr_q[PW-1:0]] <= push_dat;
    end

    assign head_dat = mem[rd_q[PW-1:0]];
    assign empty    = (wr_q == rd_q);
endmodule

// File: rtl/cache_mshr_file.sv
// MSHR file: allocates/merges block misses, issues in allocation order, retires on UUID fill.
// Request accept is same-cycle; req_ready drops on a busy match or no free slot, issue holds on !issue_ready.
module cache_mshr_file
    import cache_types_pkg::*;
#(
    parameter int ENTRIES     = MSHR_ENTRIES,
    parameter int BLOCK_WORDS = MSHR_BLOCK_WORDS,
    parameter int WORD_W      = MSHR_WORD_W,
    parameter int ADDR_W      = MSHR_ADDR_W,
    parameter int UUID_W      = MSHR_UUID_W
) (
    input  logic                         CLK,
    input  logic                         RST,
    cache_mshr_file_if.slave             bus,
    output logic [$clog2(ENTRIES+1)-1:0] occupancy,
    output logic                         empty,
    output logic                         full
);
    localparam int IDX_W  = $clog2(ENTRIES);
    localparam int SEQ_W  = UUID_W - IDX_W;
    localparam int WIDX_W = $clog2(BLOCK_WORDS);
    localparam int OFF_W  = WIDX_W + $clog2(WORD_W / 8);
    localparam int OCC_W  = $clog2(ENTRIES + 1);

    mshr_entry_t        ent_q [ENTRIES];
    logic [SEQ_W-1:0]   seq_q;
    logic [OCC_W-1:0]   occ_q;
    logic               fill_err_q;

    logic [ADDR_W-1:0]  req_blk;
    logic [WIDX_W-1:0]  req_widx;
    logic               hit, free_avail, retire;
    logic [IDX_W-1:0]   hit_idx, free_idx, retire_idx, head_idx;
    logic               fifo_empty, issue_fire, alloc, merge;

    assign req_blk  = bus.req_addr & ~ADDR_W'((1 << OFF_W) - 1);
    assign req_widx = bus.req_addr[OFF_W-1 -: WIDX_W];

    always_comb begin
        hit        = 1'b0;
        hit_idx    = '0;
        free_avail = 1'b0;
        free_idx   = '0;
        retire     = 1'b0;
        retire_idx = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (ent_q[i].state == FREE && !free_avail) begin
                free_avail = 1'b1;
                free_idx   = IDX_W'(i);
            end
            if (ent_q[i].state != FREE && ent_q[i].block_addr == req_blk) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
            // An entry issuing this very cycle is still PEND, so its fill is an error.
            if (bus.fill_valid && ent_q[i].state == ISSUED && ent_q[i].uuid == bus.fill_uuid) begin
                retire     = 1'b1;
                retire_idx = IDX_W'(i);
            end
        end
    end

    assign issue_fire = !fifo_empty && bus.issue_ready;

    always_comb begin
        bus.req_ready = free_avail;
        if (hit) begin
            bus.req_ready = (ent_q[hit_idx].state == PEND) && !(issue_fire && head_idx == hit_idx);
        end
    end

    assign merge = bus.req_valid && bus.req_ready && hit;
    assign alloc = bus.req_valid && bus.req_ready && !hit;

    assign bus.req_merged = merge;
    assign bus.req_uuid   = merge ? ent_q[hit_idx].uuid :
                            alloc ? {seq_q, free_idx} : '0;

    mshr_index_fifo #(.DEPTH(ENTRIES), .W(IDX_W)) u_index_fifo (
        .CLK      (CLK),
        .RST      (RST),
        .push     (alloc),
        .push_dat (free_idx),
        .pop      (issue_fire),
        .head_dat (head_idx),
        .empty    (fifo_empty)
    );

    assign bus.issue_valid        = !fifo_empty;
    assign bus.issue_uuid         = fifo_empty ? '0 : ent_q[head_idx].uuid;
    assign bus.issue_block_addr   = fifo_empty ? '0 : ent_q[head_idx].block_addr;
    assign bus.issue_write_status = fifo_empty ? '0 : ent_q[head_idx].write_status;
    assign bus.issue_write_block  = fifo_empty ? '0 : ent_q[head_idx].write_block;

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < ENTRIES; i++) ent_q[i] <= '0;
            seq_q      <= '0;
            occ_q      <= '0;
            fill_err_q <= 1'b0;
        end else begin
            // Alloc, merge, issue and retire always touch different entries.
            if (alloc) begin
                ent_q[free_idx].state        <= PEND;
                ent_q[free_idx].uuid         <= {seq_q, free_idx};
                ent_q[free_idx].block_addr   <= req_blk;
                ent_q[free_idx].write_status <= bus.req_rw ? (BLOCK_WORDS'(1) << req_widx) : '0;
                ent_q[free_idx].write_block  <= bus.req_rw ?
                    ((BLOCK_WORDS*WORD_W)'(bus.req_data) << (req_widx * WORD_W)) : '0;
                seq_q <= seq_q + SEQ_W'(1);
            end
            if (merge && bus.req_rw) begin
                ent_q[hit_idx].write_status[req_widx]                    <= 1'b1;
                ent_q[hit_idx].write_block[req_widx*WORD_W +: WORD_W]    <= bus.req_data;
            end
            if (issue_fire) ent_q[head_idx].state   <= ISSUED;
            if (retire)     ent_q[retire_idx].state <= FREE;
            occ_q      <= occ_q + OCC_W'(alloc) - OCC_W'(retire);
            fill_err_q <= bus.fill_valid && !retire;
        end
    end

    assign bus.fill_err = fill_err_q;
    assign occupancy    = occ_q;
    assign empty        = (occ_q == '0);
    assign full         = (occ_q == OCC_W'(ENTRIES));
endmodule

// File: tb/tb_cache_mshr_file.sv
// Directed bench for cache_mshr_file: expected issue records are queued at allocation,
// edited on merges, and compared when the entry reaches the issue port.
module tb_cache_mshr_file;
    logic       CLK = 1'b0;
    logic       RST;
    logic [3:0] occupancy;
    logic       empty;
    logic       full;

    cache_mshr_file_if bus ();

    cache_mshr_file dut (
        .CLK       (CLK),
        .RST       (RST),
        .bus       (bus),
        .occupancy (occupancy),
        .empty     (empty),
        .full      (full)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0]   uuid;
        logic [31:0]  addr;
        logic [3:0]   st;
        logic [127:0] blk;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] uid(input int s, input int i);
        return 8'((s << 3) | i);
    endfunction

    task automatic idle();
        bus.req_valid   = 1'b0;
        bus.req_rw      = 1'b0;
        bus.req_addr    = '0;
        bus.req_data    = '0;
        bus.issue_ready = 1'b0;
        bus.fill_valid  = 1'b0;
        bus.fill_uuid   = '0;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
        idle();
    endtask

    task automatic drive_req(input logic rw, input logic [31:0] a, input logic [31:0] d);
        bus.req_valid = 1'b1;
        bus.req_rw    = rw;
        bus.req_addr  = a;
        bus.req_data  = d;
    endtask

    task automatic req_chk(input string tag, input logic rdy, input logic mrg, input logic [7:0] u);
        chk({tag, ".req_ready"}, bus.req_ready, rdy);
        if (rdy) begin
            chk({tag, ".req_merged"}, bus.req_merged, mrg);
            chk({tag, ".req_uuid"}, bus.req_uuid, u);
        end
    endtask

    task automatic sb_alloc(input logic [7:0] u, input logic rw, input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        int   w;
        w      = int'((a >> 2) & 32'h3);
        e.uuid = u;
        e.addr = a & ~32'hF;
        e.st   = '0;
        e.blk  = '0;
        if (rw) begin
            e.st[w]          = 1'b1;
            e.blk[w*32 +: 32] = d;
        end
        sb.push_back(e);
    endtask

    task automatic sb_merge(input logic [7:0] u, input logic [31:0] a, input logic [31:0] d);
        int w;
        w = int'((a >> 2) & 32'h3);
        for (int i = 0; i < sb.size(); i++) begin
            if (sb[i].uuid == u) begin
                sb[i].st[w]           = 1'b1;
                sb[i].blk[w*32 +: 32] = d;
            end
        end
    endtask

    task automatic peek_issue(input string tag, input bit pop);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s observed=issue expected=no pending record", tag);
            return;
        end
        e = sb[0];
        chk({tag, ".issue_valid"}, bus.issue_valid, 1);
        chk({tag, ".issue_uuid"}, bus.issue_uuid, e.uuid);
        chk({tag, ".issue_addr"}, bus.issue_block_addr, e.addr);
        chk({tag, ".issue_status"}, bus.issue_write_status, e.st);
        chk({tag, ".issue_block"}, bus.issue_write_block, e.blk);
        if (pop) e = sb.pop_front();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle();
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        #1;
        chk("rst.req_ready", bus.req_ready, 1);
        chk("rst.issue_valid", bus.issue_valid, 0);
        chk("rst.fill_err", bus.fill_err, 0);
        chk("rst.occupancy", occupancy, 0);
        chk("rst.empty", empty, 1);
        chk("rst.full", full, 0);
        chk("rst.issue_uuid", bus.issue_uuid, 0);
        chk("rst.issue_addr", bus.issue_block_addr, 0);
        chk("rst.req_uuid", bus.req_uuid, 0);

        // First load miss stays pending while memory is not ready
        drive_req(1'b0, 32'h1000, 32'h0);
        #1;
        req_chk("load1", 1'b1, 1'b0, 8'h00);
        sb_alloc(8'h00, 1'b0, 32'h1000, 32'h0);
        step();
        peek_issue("load1", 1'b0);
        chk("load1.occupancy", occupancy, 1);
        chk("load1.empty", empty, 0);

        // Secondary store misses merge and overwrite word 2
        drive_req(1'b1, 32'h1008, 32'hAA);
        #1;
        req_chk("merge_aa", 1'b1, 1'b1, 8'h00);
        sb_merge(8'h00, 32'h1008, 32'hAA);
        step();
        peek_issue("merge_aa", 1'b0);
        chk("merge_aa.status", bus.issue_write_status, 4'b0100);
        drive_req(1'b1, 32'h1008, 32'hBB);
        #1;
        req_chk("merge_bb", 1'b1, 1'b1, 8'h00);
        sb_merge(8'h00, 32'h1008, 32'hBB);
        step();
        peek_issue("merge_bb", 1'b0);
        chk("merge_bb.occupancy", occupancy, 1);

        // Fill the remaining seven slots with distinct blocks
        for (int k = 1; k < 8; k++) begin
            drive_req(k[0], 32'(32'h1000 * (k + 1)), 32'(32'h100 + k));
            #1;
            req_chk($sformatf("alloc%0d", k), 1'b1, 1'b0, uid(k, k));
            sb_alloc(uid(k, k), k[0], 32'(32'h1000 * (k + 1)), 32'(32'h100 + k));
            step();
        end
        chk("full.full", full, 1);
        chk("full.occupancy", occupancy, 8);
        drive_req(1'b0, 32'h9000, 32'h0);
        #1;
        chk("ninth_miss.req_ready", bus.req_ready, 0);
        step();
        chk("ninth_miss.occupancy", occupancy, 8);

        // Drain in allocation order; a hit on the issuing head is refused,
        // while a merge into a different pending entry proceeds
        bus.issue_ready = 1'b1;
        drive_req(1'b0, 32'h1004, 32'h0);
        #1;
        chk("hit_issuing_head.req_ready", bus.req_ready, 0);
        peek_issue("drain0", 1'b1);
        step();
        bus.issue_ready = 1'b1;
        drive_req(1'b1, 32'h3004, 32'hCC);
        #1;
        req_chk("merge_during_issue", 1'b1, 1'b1, uid(2, 2));
        sb_merge(uid(2, 2), 32'h3004, 32'hCC);
        peek_issue("drain1", 1'b1);
        step();
        for (int k = 2; k < 8; k++) begin
            bus.issue_ready = 1'b1;
            #1;
            peek_issue($sformatf("drain%0d", k), 1'b1);
            step();
        end
        chk("drained.issue_valid", bus.issue_valid, 0);
        chk("drained.occupancy", occupancy, 8);

        // Store to an ISSUED block waits for its fill, then reallocates
        drive_req(1'b1, 32'h2000, 32'hDD);
        #1;
        chk("issued_hit0.req_ready", bus.req_ready, 0);
        step();
        drive_req(1'b1, 32'h2000, 32'hDD);
        bus.fill_valid = 1'b1;
        bus.fill_uuid  = uid(1, 1);
        #1;
        chk("issued_hit_with_fill.req_ready", bus.req_ready, 0);
        step();
        chk("fill_ok.fill_err", bus.fill_err, 0);
        chk("fill_ok.occupancy", occupancy, 7);
        drive_req(1'b1, 32'h2000, 32'hDD);
        #1;
        req_chk("realloc", 1'b1, 1'b0, uid(8, 1));
        sb_alloc(uid(8, 1), 1'b1, 32'h2000, 32'hDD);
        step();
        chk("realloc.occupancy", occupancy, 8);
        chk("realloc.full", full, 1);

        // Unknown fill tag
        bus.fill_valid = 1'b1;
        bus.fill_uuid  = 8'h7F;
        step();
        chk("bad_fill.fill_err", bus.fill_err, 1);
        chk("bad_fill.occupancy", occupancy, 8);
        step();
        chk("bad_fill.pulse_end", bus.fill_err, 0);

        // Fill in the same cycle as the entry's own issue handshake
        bus.issue_ready = 1'b1;
        bus.fill_valid  = 1'b1;
        bus.fill_uuid   = uid(8, 1);
        #1;
        peek_issue("issue_fill_same", 1'b1);
        step();
        chk("issue_fill_same.fill_err", bus.fill_err, 1);
        chk("issue_fill_same.occupancy", occupancy, 8);
        chk("issue_fill_same.issue_valid", bus.issue_valid, 0);

        // Slot freed by a fill is only allocatable from the next cycle
        bus.fill_valid = 1'b1;
        bus.fill_uuid  = uid(3, 3);
        drive_req(1'b0, 32'hA000, 32'h0);
        #1;
        chk("fill_same_cycle.req_ready", bus.req_ready, 0);
        step();
        chk("fill_same_cycle.occupancy", occupancy, 7);
        chk("fill_same_cycle.fill_err", bus.fill_err, 0);
        drive_req(1'b0, 32'hA000, 32'h0);
        #1;
        req_chk("alloc_idx3", 1'b1, 1'b0, uid(9, 3));
        sb_alloc(uid(9, 3), 1'b0, 32'hA000, 32'h0);
        step();
        chk("alloc_idx3.occupancy", occupancy, 8);

        // Allocate, issue and retire all in one cycle
        bus.fill_valid = 1'b1;
        bus.fill_uuid  = uid(4, 4);
        step();
        chk("free4.occupancy", occupancy, 7);
        bus.issue_ready = 1'b1;
        bus.fill_valid  = 1'b1;
        bus.fill_uuid   = uid(5, 5);
        drive_req(1'b0, 32'hB000, 32'h0);
        #1;
        req_chk("triple", 1'b1, 1'b0, uid(10, 4));
        peek_issue("triple", 1'b1);
        sb_alloc(uid(10, 4), 1'b0, 32'hB000, 32'h0);
        step();
        chk("triple.occupancy", occupancy, 7);
        chk("triple.fill_err", bus.fill_err, 0);
        peek_issue("triple_next", 1'b0);

        // Reset mid-operation discards everything, including in-flight tags
        RST = 1'b1;
        step();
        RST = 1'b0;
        sb.delete();
        chk("midrst.occupancy", occupancy, 0);
        chk("midrst.empty", empty, 1);
        chk("midrst.issue_valid", bus.issue_valid, 0);
        bus.fill_valid = 1'b1;
        bus.fill_uuid  = uid(6, 6);
        step();
        chk("stale_fill.fill_err", bus.fill_err, 1);
        drive_req(1'b0, 32'h1000, 32'h0);
        #1;
        req_chk("post_rst_alloc", 1'b1, 1'b0, 8'h00);
        sb_alloc(8'h00, 1'b0, 32'h1000, 32'h0);
        step();
        chk("post_rst_alloc.occupancy", occupancy, 1);
        peek_issue("post_rst_alloc", 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
